// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: states, opcodes, ALU codes and select encodings shared by control and datapath
package control_fsm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_COMMIT, S_HALT} state_t;
  localparam logic [5:0] OP_LD   = 6'h20;
  localparam logic [5:0] OP_ST   = 6'h21;
  localparam logic [5:0] OP_BR   = 6'h22;
  localparam logic [5:0] OP_BZ   = 6'h23;
  localparam logic [5:0] OP_BPL  = 6'h24;
  localparam logic [5:0] OP_BMI  = 6'h25;
  localparam logic [5:0] OP_CALL = 6'h26;
  localparam logic [5:0] OP_RET  = 6'h27;
  localparam logic [5:0] OP_PUSH = 6'h28;
  localparam logic [5:0] OP_POP  = 6'h29;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [1:0] PC_SEQ = 2'd0, PC_ALU = 2'd1, PC_MEM = 2'd2;
  localparam logic [1:0] A1_RS = 2'd0, A1_PC = 2'd1, A1_SP = 2'd2;
  localparam logic A2_RT = 1'b0, A2_IMM = 1'b1;
  localparam logic DST_RD = 1'b0, DST_RT = 1'b1;
  localparam logic WB_ALU = 1'b0, WB_MEM = 1'b1;
  localparam logic MA_ALU = 1'b0, MA_SP = 1'b1;
  localparam logic MD_PC4 = 1'b0, MD_RT = 1'b1;
  localparam logic SPU_DEC = 1'b0, SPU_INC = 1'b1;
  localparam logic SPL_DEC = 1'b0, SPL_SP = 1'b1;
  localparam logic SPW_ADDER = 1'b0, SPW_MEM = 1'b1;
  typedef struct packed {
    logic       reg_dst_sel;
    logic [1:0] alu_sel1;
    logic       alu_sel2;
    logic [3:0] alu_op;
    logic [1:0] pc_sel;
    logic       sp_update_sel;
    logic       sp_load_sel;
    logic       sp_write_sel;
    logic       mem_addr_sel;
    logic       mem_data_sel;
    logic       reg_write_sel;
    logic       reg_write;
    logic       mem_write;
    logic       sp_write;
    logic       pc_write;
  } ctrl_t;
  function automatic logic is_defined(input logic [5:0] op);
    return op <= OP_POP || op == OP_HALT;
  endfunction
endpackage

// File: rtl/control_fsm_decode.sv
// ctrl_decode: combinational map from opcode and flags to the select/strobe bundle
module ctrl_decode
  import control_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic       eqz,
  input  logic       gz,
  input  logic       lz,
  output ctrl_t      ctl
);
  logic taken;
  assign taken = op == OP_BR || (op == OP_BZ && eqz) || (op == OP_BPL && gz) || (op == OP_BMI && lz);
  // decode one opcode; undefined opcodes fall through as a NOP that only advances the pc
  always_comb begin
    ctl = '0;
    ctl.alu_op = ALU_ADD;
    ctl.pc_write = 1'b1;
    if (op[5:4] == 2'b00) begin
      ctl.alu_op = op[3:0];
      ctl.reg_dst_sel = DST_RD;
      ctl.reg_write = 1'b1;
    end else if (op[5:4] == 2'b01) begin
      ctl.alu_op = op[3:0];
      ctl.alu_sel2 = A2_IMM;
      ctl.reg_dst_sel = DST_RT;
      ctl.reg_write = 1'b1;
    end else begin
      case (op)
        OP_LD: begin
          ctl.alu_sel2 = A2_IMM;
          ctl.reg_dst_sel = DST_RT;
          ctl.reg_write_sel = WB_MEM;
          ctl.reg_write = 1'b1;
        end
        OP_ST: begin
          ctl.alu_sel2 = A2_IMM;
          ctl.mem_data_sel = MD_RT;
          ctl.mem_write = 1'b1;
        end
        OP_BR, OP_BZ, OP_BPL, OP_BMI: begin
          ctl.alu_sel1 = A1_PC;
          ctl.alu_sel2 = A2_IMM;
          ctl.pc_sel = taken ? PC_ALU : PC_SEQ;
        end
        OP_CALL: begin
          ctl.alu_sel1 = A1_PC;
          ctl.alu_sel2 = A2_IMM;
          ctl.pc_sel = PC_ALU;
          ctl.mem_addr_sel = MA_SP;
          ctl.sp_load_sel = SPL_DEC;
          ctl.mem_data_sel = MD_PC4;
          ctl.sp_update_sel = SPU_DEC;
          ctl.sp_write_sel = SPW_ADDER;
          ctl.mem_write = 1'b1;
          ctl.sp_write = 1'b1;
        end
        OP_RET: begin
          ctl.mem_addr_sel = MA_SP;
          ctl.sp_load_sel = SPL_SP;
          ctl.pc_sel = PC_MEM;
          ctl.sp_update_sel = SPU_INC;
          ctl.sp_write = 1'b1;
        end
        OP_PUSH: begin
          ctl.mem_addr_sel = MA_SP;
          ctl.sp_load_sel = SPL_DEC;
          ctl.mem_data_sel = MD_RT;
          ctl.sp_update_sel = SPU_DEC;
          ctl.mem_write = 1'b1;
          ctl.sp_write = 1'b1;
        end
        OP_POP: begin
          ctl.mem_addr_sel = MA_SP;
          ctl.sp_load_sel = SPL_SP;
          ctl.reg_dst_sel = DST_RT;
          ctl.reg_write_sel = WB_MEM;
          ctl.sp_update_sel = SPU_INC;
          ctl.reg_write = 1'b1;
          ctl.sp_write = 1'b1;
        end
        OP_HALT: ctl.pc_write = 1'b0;
        default: ctl.pc_write = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: instruction sequencer (IDLE/FETCH/EXEC/COMMIT/HALT); ILLEGAL_OP_TRAP_EN halts on undefined opcodes
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        write_clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        eqz,
  input  logic        gz,
  input  logic        lz,
  output logic        reg_dst_sel,
  output logic [1:0]  alu_sel1,
  output logic        alu_sel2,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_sel,
  output logic        sp_update_sel,
  output logic        sp_load_sel,
  output logic        sp_write_sel,
  output logic        mem_addr_sel,
  output logic        mem_data_sel,
  output logic        reg_write_sel,
  output logic        reg_write_signal,
  output logic        mem_write_signal,
  output logic        sp_write_signal,
  output logic        pc_write_signal,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] instr_count
);
  state_t     state, state_n;
  logic [5:0] op_q;
  logic [3:0] wait_q;
  ctrl_t      ctl, sel;
  logic       active, commit, trap;
  ctrl_decode u_decode (.op(op_q), .eqz(eqz), .gz(gz), .lz(lz), .ctl(ctl));
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;
  assign trap = !is_defined(op_q);
  assign illegal_op = illegal_q;
  // sticky trap flag, raised when an undefined opcode commits
  always_ff @(posedge write_clk) begin
    if (rst) illegal_q <= 1'b0;
    else if (state == S_COMMIT && trap) illegal_q <= 1'b1;
  end
`else
  assign trap = 1'b0;
  assign illegal_op = 1'b0;
`endif
  assign active = state == S_EXEC || state == S_COMMIT;
  assign commit = state == S_COMMIT && !rst;
  assign sel = active ? ctl : '0;
  assign halted = state == S_HALT;
  assign {reg_dst_sel, alu_sel1, alu_sel2, alu_op, pc_sel} = {sel.reg_dst_sel, sel.alu_sel1, sel.alu_sel2, sel.alu_op, sel.pc_sel};
  assign {sp_update_sel, sp_load_sel, sp_write_sel} = {sel.sp_update_sel, sel.sp_load_sel, sel.sp_write_sel};
  assign {mem_addr_sel, mem_data_sel, reg_write_sel} = {sel.mem_addr_sel, sel.mem_data_sel, sel.reg_write_sel};
  assign reg_write_signal = commit & ctl.reg_write;
  assign mem_write_signal = commit & ctl.mem_write;
  assign sp_write_signal = commit & ctl.sp_write;
  assign pc_write_signal = commit & ctl.pc_write & !trap;
  // next state: EXEC holds for MEM_WAIT cycles, COMMIT returns to FETCH only while run stays high
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_n = S_EXEC;
      S_EXEC:   state_n = wait_q == 4'(MEM_WAIT - 1) ? S_COMMIT : S_EXEC;
      S_COMMIT: state_n = (op_q == OP_HALT || trap) ? S_HALT : run ? S_FETCH : S_IDLE;
      default:  state_n = S_HALT;
    endcase
  end
  // state, latched opcode, EXEC wait counter and retired-instruction count
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      wait_q <= '0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH) op_q <= opcode;
      wait_q <= state == S_EXEC ? wait_q + 4'd1 : 4'd0;
      if (state == S_COMMIT) instr_count <= instr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scenarios plus random run/opcode/flag stimulus checked against a behavioural model
module tb_control_fsm;
  localparam int MW = 1;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic write_clk = 1'b0, rst = 1'b1, run = 1'b0, eqz = 1'b0, gz = 1'b0, lz = 1'b0;
  logic [5:0] opcode = '0;
  logic reg_dst_sel, alu_sel2, sp_update_sel, sp_load_sel, sp_write_sel, mem_addr_sel, mem_data_sel, reg_write_sel;
  logic [1:0] alu_sel1, pc_sel;
  logic [3:0] alu_op;
  logic reg_write_signal, mem_write_signal, sp_write_signal, pc_write_signal, halted, illegal_op;
  logic [15:0] instr_count;
  control_fsm #(.MEM_WAIT(MW)) dut (
    .write_clk(write_clk), .rst(rst), .run(run), .opcode(opcode), .eqz(eqz), .gz(gz), .lz(lz),
    .reg_dst_sel(reg_dst_sel), .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .alu_op(alu_op), .pc_sel(pc_sel),
    .sp_update_sel(sp_update_sel), .sp_load_sel(sp_load_sel), .sp_write_sel(sp_write_sel),
    .mem_addr_sel(mem_addr_sel), .mem_data_sel(mem_data_sel), .reg_write_sel(reg_write_sel),
    .reg_write_signal(reg_write_signal), .mem_write_signal(mem_write_signal), .sp_write_signal(sp_write_signal),
    .pc_write_signal(pc_write_signal), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );
  always #5 write_clk = ~write_clk;
  typedef struct packed {
    logic rds; logic [1:0] as1; logic as2; logic [3:0] aop; logic [1:0] psel;
    logic spu, spl, spw, mas, mds, rws, rw, mw, sw, pw;
  } exp_t;
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t exp_of(input logic [5:0] op, input logic z, input logic g, input logic l);
    exp_t e;
    int o;
    o = int'(op);
    e = '0;
    e.pw = 1'b1;
    if (o < 16) begin
      e.aop = op[3:0]; e.rw = 1'b1;
    end else if (o < 32) begin
      e.aop = op[3:0]; e.as2 = 1'b1; e.rds = 1'b1; e.rw = 1'b1;
    end else if (o == 32) begin
      e.as2 = 1'b1; e.rds = 1'b1; e.rws = 1'b1; e.rw = 1'b1;
    end else if (o == 33) begin
      e.as2 = 1'b1; e.mds = 1'b1; e.mw = 1'b1;
    end else if (o >= 34 && o <= 37) begin
      e.as1 = 2'd1; e.as2 = 1'b1;
      e.psel = (o == 34 || (o == 35 && z) || (o == 36 && g) || (o == 37 && l)) ? 2'd1 : 2'd0;
    end else if (o == 38) begin
      e.as1 = 2'd1; e.as2 = 1'b1; e.psel = 2'd1; e.mas = 1'b1; e.mw = 1'b1; e.sw = 1'b1;
    end else if (o == 39) begin
      e.mas = 1'b1; e.spl = 1'b1; e.psel = 2'd2; e.spu = 1'b1; e.sw = 1'b1;
    end else if (o == 40) begin
      e.mas = 1'b1; e.mds = 1'b1; e.mw = 1'b1; e.sw = 1'b1;
    end else if (o == 41) begin
      e.mas = 1'b1; e.spl = 1'b1; e.rds = 1'b1; e.rws = 1'b1; e.spu = 1'b1; e.rw = 1'b1; e.sw = 1'b1;
    end else if (o == 63) begin
      e.pw = 1'b0;
    end else begin
      e.pw = !TRAP;
    end
    return e;
  endfunction
  // model phases: 0 idle, 1 fetch, 2 exec, 3 commit, 4 halt
  int m_ph = 0, m_left = 0;
  logic [5:0] m_op = '0;
  logic [15:0] m_cnt = '0;
  logic m_ill = 1'b0;
  bit preload = 1'b0;
  always @(posedge write_clk) begin
    if (rst) begin
      m_ph = 0; m_op = '0; m_cnt = '0; m_ill = 1'b0;
    end else begin
      if (preload) m_cnt = 16'hFFFF;
      case (m_ph)
        0: if (run) m_ph = 1;
        1: begin m_op = opcode; m_left = MW; m_ph = 2; end
        2: begin m_left--; if (m_left == 0) m_ph = 3; end
        3: begin
          m_cnt = m_cnt + 16'd1;
          if (m_op == 6'h3F) m_ph = 4;
          else if (TRAP && m_op > 6'h29) begin m_ill = 1'b1; m_ph = 4; end
          else m_ph = run ? 1 : 0;
        end
        default: m_ph = 4;
      endcase
    end
  end
  // compare every output against the model away from the active edge
  always @(negedge write_clk) begin
    exp_t e, a;
    e = exp_of(m_op, eqz, gz, lz);
    if (!(m_ph == 2 || m_ph == 3)) e = '0;
    if (m_ph != 3 || rst) begin e.rw = 1'b0; e.mw = 1'b0; e.sw = 1'b0; e.pw = 1'b0; end
    a = {reg_dst_sel, alu_sel1, alu_sel2, alu_op, pc_sel, sp_update_sel, sp_load_sel, sp_write_sel,
         mem_addr_sel, mem_data_sel, reg_write_sel, reg_write_signal, mem_write_signal, sp_write_signal, pc_write_signal};
    chk("ctl", 32'(a), 32'(e));
    chk("halted", 32'(halted), 32'(m_ph == 4));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
  end
  task automatic tick();
    @(posedge write_clk);
    #2;
  endtask
  task automatic go_commit(input logic [5:0] op);
    opcode = op;
    run = 1'b1;
    repeat (2 + MW) tick();
    run = 1'b0;
    #1;
  endtask
  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pcw", 32'(pc_write_signal), 32'd0);
    opcode = 6'h00;
    run = 1'b1;
    tick();
    chk("fetch_rw", 32'(reg_write_signal), 32'd0);
    repeat (MW + 1) tick();
    run = 1'b0;
    #1;
    chk("r_commit_rw", 32'(reg_write_signal), 32'd1);
    chk("r_commit_aop", 32'(alu_op), 32'd0);
    tick();
    chk("r_count", 32'(instr_count), 32'd1);
    chk("r_idle_rw", 32'(reg_write_signal), 32'd0);
    eqz = 1'b1;
    go_commit(6'h23);
    chk("bz_taken_psel", 32'(pc_sel), 32'd1);
    chk("bz_taken_pcw", 32'(pc_write_signal), 32'd1);
    tick();
    eqz = 1'b0;
    go_commit(6'h23);
    chk("bz_not_psel", 32'(pc_sel), 32'd0);
    chk("bz_not_pcw", 32'(pc_write_signal), 32'd1);
    tick();
    go_commit(6'h26);
    chk("call_strobes", 32'({mem_write_signal, sp_write_signal, pc_write_signal}), 32'b111);
    chk("call_sels", 32'({mem_addr_sel, sp_load_sel, mem_data_sel, pc_sel}), 32'b10001);
    tick();
    chk("call_once", 32'(mem_write_signal), 32'd0);
    go_commit(6'h2A);
    chk("undef_pcw", 32'(pc_write_signal), 32'(!TRAP));
    chk("undef_rw_mw", 32'({reg_write_signal, mem_write_signal}), 32'd0);
    tick();
    chk("undef_ill", 32'(illegal_op), 32'(TRAP));
    chk("undef_halt", 32'(halted), 32'(TRAP));
    do_reset();
    go_commit(6'h3F);
    chk("halt_pcw", 32'(pc_write_signal), 32'd0);
    tick();
    chk("halt_flag", 32'(halted), 32'd1);
    run = 1'b1;
    repeat (4) tick();
    chk("halt_quiet", 32'({reg_write_signal, pc_write_signal, alu_sel2}), 32'd0);
    chk("halt_stays", 32'(halted), 32'd1);
    do_reset();
    chk("halt_cleared", 32'(halted), 32'd0);
    go_commit(6'h00);
    rst = 1'b1;
    #1;
    chk("rst_commit_rw", 32'(reg_write_signal), 32'd0);
    chk("rst_commit_pcw", 32'(pc_write_signal), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge write_clk);
    #1;
    force dut.instr_count = 16'hFFFF;
    preload = 1'b1;
    tick();
    release dut.instr_count;
    preload = 1'b0;
    chk("preload", 32'(instr_count), 32'hFFFF);
    opcode = 6'h10;
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    repeat (MW) tick();
    #1;
    chk("drop_rw", 32'(reg_write_signal), 32'd1);
    chk("drop_as2", 32'(alu_sel2), 32'd1);
    tick();
    chk("wrap", 32'(instr_count), 32'd0);
    tick();
    chk("drop_idle", 32'({pc_write_signal, alu_sel2}), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = ($urandom_range(0, 99) < 2) || (m_ph == 4 && $urandom_range(0, 3) == 0);
      run = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 99);
      opcode = r < 40 ? 6'($urandom_range(0, 31)) : r < 80 ? 6'($urandom_range(32, 41)) :
               r < 88 ? 6'h3F : 6'($urandom_range(42, 62));
      {eqz, gz, lz} = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    run = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
